ysyx_23060201_lsu: RTL and testbench

- Load/store unit directly upstream of the data-memory stage. Accepts one memory micro-op from execute over a valid/ready handshake.
- Drives the memory port with a word-aligned address, byte-lane mask and lane-shifted write data.
- Captures the combinational read data, then aligns and sign- or zero-extends it.
- Returns the result to write-back over a second valid/ready handshake. One operation is in flight at a time.

---
 rtl/ysyx_23060201_lsu_pkg.sv | 70 +++++++
 rtl/ysyx_23060201_lsu_if.sv | 48 ++++
 rtl/ysyx_23060201_lsu_align.sv | 23 ++
 rtl/ysyx_23060201_lsu.sv | 117 +++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the LSU: funct3 encodings, FSM states, lane-mask bases.
// Macro YSYX_23060201_LSU_MISALIGN_TRAP_EN enables the misalignment short-cut in the top.
package ysyx_23060201_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef struct packed {
      logic       is_store;
      logic [2:0] funct3;
      logic [4:0] rd;
   } meta_t;

   // Unknown funct3 encodings fall through to a word access.
   function automatic size_t access_size(input logic is_store, input logic [2:0] funct3);
      size_t sz;
      sz = SZ_WORD;
      if (is_store) begin
         case (funct3)
            F3_SB:   sz = SZ_BYTE;
            F3_SH:   sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic [3:0] lane_base(input size_t sz);
      logic [3:0] m;
      case (sz)
         SZ_BYTE: m = MASK_BYTE;
         SZ_HALF: m = MASK_HALF;
         default: m = MASK_WORD;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] offset);
      return ((sz == SZ_HALF) && offset[0]) || ((sz == SZ_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_if.sv
// Bundle of the execute request, write-back response and data-memory port of the LSU.
// master = surrounding pipeline/memory, slave = the LSU itself.
interface ysyx_23060201_lsu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_is_store;
   logic [2:0]            in_funct3;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_wdata;
   logic [4:0]            in_rd;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_rdata;
   logic [4:0]            out_rd;
   logic                  out_is_load;
   logic                  out_misalign;

   logic                  mem_ren;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic [7:0]            mem_rmask;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [7:0]            mem_wmask;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
      input  in_ready,
      input  out_valid, out_rdata, out_rd, out_is_load, out_misalign,
      output out_ready,
      input  mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
      output in_ready,
      output out_valid, out_rdata, out_rd, out_is_load, out_misalign,
      input  out_ready,
      output mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/ysyx_23060201_lsu_align.sv
// Load aligner: shifts the captured word down by the byte offset and extends per funct3.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module ysyx_23060201_lsu_align
   import ysyx_23060201_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);
   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {offset, 3'b000};
      case (funct3)
         F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  result = {24'h0, shifted[7:0]};
         F3_LHU:  result = {16'h0, shifted[15:0]};
         default: result = shifted;
      endcase
   end
endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Single-outstanding load/store unit: IDLE -> ACCESS (one memory cycle) -> RESP.
// Latency: accept at edge N, memory access in N+1, out_valid from N+2; in_ready low until RESP drains.
// Backpressure: RESP holds all outputs while out_ready is low; YSYX_23060201_LSU_MISALIGN_TRAP_EN skips ACCESS on misalignment.
module ysyx_23060201_lsu
   import ysyx_23060201_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   ysyx_23060201_lsu_if.slave bus
);
   state_t                state_q, state_d;
   meta_t                 meta_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] load_res;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [3:0]            lane_mask;
   logic                  accept_vld;
   logic                  trap_now;
   logic                  res_misalign;

   assign accept_vld = bus.in_valid && (state_q == ST_IDLE);
   assign word_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   // Shifting in a 4-bit context drops lanes past byte 3 for misaligned accesses.
   assign lane_mask  = lane_base(access_size(meta_q.is_store, meta_q.funct3)) << addr_q[1:0];

`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
   logic misalign_q;

   assign trap_now     = is_misaligned(access_size(bus.in_is_store, bus.in_funct3), bus.in_addr[1:0]);
   assign res_misalign = misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          misalign_q <= 1'b0;
      else if (accept_vld) misalign_q <= trap_now;
   end
`else
   assign trap_now     = 1'b0;
   assign res_misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         meta_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_vld) begin
            meta_q.is_store <= bus.in_is_store;
            meta_q.funct3   <= bus.in_funct3;
            meta_q.rd       <= bus.in_rd;
            addr_q          <= bus.in_addr;
            wdata_q         <= bus.in_wdata;
         end
         if ((state_q == ST_ACCESS) && !meta_q.is_store) rdata_q <= bus.mem_rdata;
      end
   end

   ysyx_23060201_lsu_align u_align (
      .word   (rdata_q),
      .offset (addr_q[1:0]),
      .funct3 (meta_q.funct3),
      .result (load_res)
   );

   always_comb begin
      state_d          = state_q;
      bus.in_ready     = 1'b0;
      bus.out_valid    = 1'b0;
      bus.out_rdata    = '0;
      bus.out_rd       = '0;
      bus.out_is_load  = 1'b0;
      bus.out_misalign = 1'b0;
      bus.mem_ren      = 1'b0;
      bus.mem_raddr    = '0;
      bus.mem_rmask    = '0;
      bus.mem_wen      = 1'b0;
      bus.mem_waddr    = '0;
      bus.mem_wmask    = '0;
      bus.mem_wdata    = '0;
      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = trap_now ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (meta_q.is_store) begin
               bus.mem_wen   = 1'b1;
               bus.mem_waddr = word_addr;
               bus.mem_wmask = {4'b0000, lane_mask};
               bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
            end else begin
               bus.mem_ren   = 1'b1;
               bus.mem_raddr = word_addr;
               bus.mem_rmask = {4'b0000, lane_mask};
            end
         end
         ST_RESP: begin
            bus.out_valid    = 1'b1;
            bus.out_rd       = meta_q.rd;
            bus.out_is_load  = !meta_q.is_store;
            bus.out_misalign = res_misalign;
            if (!meta_q.is_store && !res_misalign) bus.out_rdata = load_res;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Randomized bench for the LSU against a byte-level memory and result model.
module tb_ysyx_23060201_lsu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   ren_cnt = 0;
   int   wen_cnt = 0;
   int   both_cnt = 0;

   logic [31:0] mem_arr [16];
   logic [31:0] ref_mem [16];

   always #5 clk = ~clk;

   ysyx_23060201_lsu_if bus ();

   ysyx_23060201_lsu u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.mem_rdata = mem_arr[bus.mem_raddr[5:2]];

   always @(posedge clk) begin
      if (bus.mem_wen) begin
         for (int i = 0; i < 4; i++)
            if (bus.mem_wmask[i]) mem_arr[bus.mem_waddr[5:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
      if (bus.mem_ren) ren_cnt <= ren_cnt + 1;
      if (bus.mem_wen) wen_cnt <= wen_cnt + 1;
      if (bus.mem_ren && bus.mem_wen) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic st, input logic [2:0] f3);
      if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   task automatic check_resp(input string pfx, input logic [31:0] res, input logic [4:0] rd,
                             input logic st, input logic trap);
      check({pfx, "_out_valid"}, bus.out_valid, 1);
      check({pfx, "_in_ready"}, bus.in_ready, 0);
      check({pfx, "_rdata"}, bus.out_rdata, res);
      check({pfx, "_rd"}, bus.out_rd, rd);
      check({pfx, "_is_load"}, bus.out_is_load, !st);
      check({pfx, "_misalign"}, bus.out_misalign, trap);
      check({pfx, "_mem_en"}, {bus.mem_ren, bus.mem_wen}, 0);
   endtask

   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int hold);
      int          n;
      int          off;
      int          r0;
      int          w0;
      logic        sgn;
      logic        trap;
      logic [31:0] mask;
      logic [31:0] exp_wdata;
      logic [31:0] word;
      logic [31:0] res;
      logic [31:0] waddr;
      logic [3:0]  m4;

      n         = nbytes(st, f3);
      off       = int'(addr & 32'h3);
      mask      = (((32'h1 << n) - 1) << off) & 32'hF;
      exp_wdata = wd << (8 * off);
      waddr     = addr & ~32'h3;
      word      = ref_mem[addr[5:2]];
      sgn       = !(f3 == 3'b100 || f3 == 3'b101);
      trap      = 1'b0;
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
      trap = (n == 2 && off % 2 == 1) || (n == 4 && off != 0);
`endif
      res = word >> (8 * off);
      if (n == 1) begin
         res = res & 32'hFF;
         if (sgn && res[7]) res = res | 32'hFFFF_FF00;
      end else if (n == 2) begin
         res = res & 32'hFFFF;
         if (sgn && res[15]) res = res | 32'hFFFF_0000;
      end
      if (st || trap) res = 32'h0;

      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 1);
      r0 = ren_cnt;
      w0 = wen_cnt;
      bus.in_valid    = 1'b1;
      bus.in_is_store = st;
      bus.in_funct3   = f3;
      bus.in_addr     = addr;
      bus.in_wdata    = wd;
      bus.in_rd       = rd;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (!trap) begin
         check("acc_in_ready", bus.in_ready, 0);
         check("acc_out_valid", bus.out_valid, 0);
         check("acc_ren", bus.mem_ren, !st);
         check("acc_wen", bus.mem_wen, st);
         if (st) begin
            check("acc_waddr", bus.mem_waddr, waddr);
            check("acc_wmask", bus.mem_wmask, mask);
            check("acc_wdata", bus.mem_wdata, exp_wdata);
            check("acc_rmask", bus.mem_rmask, 0);
         end else begin
            check("acc_raddr", bus.mem_raddr, waddr);
            check("acc_rmask", bus.mem_rmask, mask);
            check("acc_wmask", bus.mem_wmask, 0);
         end
         @(negedge clk);
      end
      check_resp("resp", res, rd, st, trap);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_resp("hold", res, rd, st, trap);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("done_in_ready", bus.in_ready, 1);
      check("done_out_valid", bus.out_valid, 0);
      check("ren_pulses", ren_cnt - r0, (!st && !trap) ? 1 : 0);
      check("wen_pulses", wen_cnt - w0, (st && !trap) ? 1 : 0);
      if (st && !trap) begin
         m4 = mask[3:0];
         for (int i = 0; i < 4; i++)
            if (m4[i]) ref_mem[addr[5:2]][8*i +: 8] = exp_wdata[8*i +: 8];
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_is_store = 1'b0;
      bus.in_funct3   = 3'b000;
      bus.in_addr     = 32'h0;
      bus.in_wdata    = 32'h0;
      bus.in_rd       = 5'd0;
      bus.out_ready   = 1'b0;

      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_rdata", bus.out_rdata, 0);
      check("rst_mem_en", {bus.mem_ren, bus.mem_wen}, 0);
      check("rst_masks", {bus.mem_rmask, bus.mem_wmask}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++)
         do_op(1'b1, 3'b010, 32'h8000_0000 + 32'(4 * i), $urandom, 5'(i), 0);

      do_op(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd3, 0);
      do_op(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd4, 0);
      do_op(1'b1, 3'b010, 32'h8000_0010, 32'h80F0_7F01, 5'd0, 0);
      do_op(1'b0, 3'b000, 32'h8000_0013, 32'h0, 5'd5, 0);
      do_op(1'b0, 3'b100, 32'h8000_0013, 32'h0, 5'd6, 0);
      do_op(1'b0, 3'b001, 32'h8000_0012, 32'h0, 5'd7, 0);
      do_op(1'b0, 3'b101, 32'h8000_0010, 32'h0, 5'd8, 0);
      do_op(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd9, 5);
      do_op(1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd10, 0);
      do_op(1'b1, 3'b001, 32'h8000_0007, 32'h1234_5678, 5'd11, 0);
      do_op(1'b0, 3'b111, 32'h8000_0008, 32'h0, 5'd12, 0);

      // Reset while a store is in its memory cycle: nothing may be written.
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_is_store = 1'b1;
      bus.in_funct3   = 3'b010;
      bus.in_addr     = 32'h8000_0020;
      bus.in_wdata    = 32'h1122_3344;
      bus.in_rd       = 5'd13;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("rstmid_wen_before", bus.mem_wen, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_in_ready", bus.in_ready, 1);
      check("rstmid_mem_en", {bus.mem_ren, bus.mem_wen}, 0);
      check("rstmid_wmask", bus.mem_wmask, 0);
      check("rstmid_wdata", bus.mem_wdata, 0);
      check("rstmid_out_valid", bus.out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd14, 0);

      for (int i = 0; i < 60; i++)
         do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 2));

      check("never_both_en", both_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
